sym_dec: RTL and testbench
==========================

Name: sym_dec

Overview:
- Downstream neighbour of the NYQ Nyquist filter. Consumes its 24-bit sample stream, one sample per clock.
- Keeps one sample out of every M, at a programmable phase P. Scales the kept sample by a programmable right shift with rounding and saturates it to OUT_WIDTH.
- Delivers results over a valid/ready handshake through a 2-entry output buffer.
- Configured over the same WrEn/Addr/data register bus used by NYQ.

Parameters:
- IN_WIDTH, 24, input sample width (signed two's complement).
- OUT_WIDTH, 16, output sample width (signed).
- ADDR_WIDTH, 5, config address width.
- MEM_WIDTH, 32, config data width.
- CNT_WIDTH, 4, decimation counter width; M max = 2^CNT_WIDTH.

Ports:
- Clk_CI  in  1  clock.
- Rst_RI  in  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- WrEn_SI  in  1  config write strobe.
- Addr_DI  in  ADDR_WIDTH  config register address.
- PAR_In_DI  in  MEM_WIDTH  config write data.
- DEC_In_DI  in  IN_WIDTH  sample from NYQ_Out_DO, valid every cycle.
- Out_Valid_SO  out  1  output sample valid.
- Out_Ready_SI  in  1  downstream ready.
- DEC_Out_DO  out  OUT_WIDTH  decimated, scaled sample.
- Ovf_SO  out  1  sticky flag: a sample was dropped because the buffer was full.

Behaviour:
- Registers, all written on WrEn_SI=1 at the clock edge:
  - addr 0: RATIO, bits[CNT_WIDTH:0]. M = RATIO; RATIO=0 is treated as M=1; values above 2^CNT_WIDTH are clamped to 2^CNT_WIDTH.
  - addr 1: PHASE, bits[CNT_WIDTH-1:0]. If PHASE >= M, the effective phase is M-1.
  - addr 2: SHIFT, bits[4:0], range 0..IN_WIDTH-1. Larger values clamp to IN_WIDTH-1.
  - addr 3: CTRL. bit0 = EN. Any write to CTRL clears Ovf_SO.
  - Other addresses are ignored.
- Reset values: RATIO=1, PHASE=0, SHIFT=IN_WIDTH-OUT_WIDTH, EN=0, counter=0, buffer empty, Out_Valid_SO=0, DEC_Out_DO=0, Ovf_SO=0.
- Counter:
  - When EN=1, cnt increments each clock and wraps from M-1 to 0.
  - A sample is selected when cnt equals the effective phase.
  - A write to addr 0, 1 or 3 forces cnt=0 on the next cycle.
  - When EN=0, cnt is held at 0, no samples are selected, and the buffer keeps draining.
- Arithmetic, in the stage-2 register:
  - Sign-extend the input to IN_WIDTH+1 bits.
  - If SHIFT>0, add 2^(SHIFT-1) (round half up).
  - Arithmetic right shift by SHIFT.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Latency:
  - A sample selected at edge t is in the stage-2 register at t+1 and enters the buffer at t+2.
  - Out_Valid_SO rises at t+2 if the buffer was empty. There is no combinational path from input to output.
- Buffer (2-entry FIFO):
  - The head drives DEC_Out_DO and Out_Valid_SO = not empty.
  - Pop when Out_Valid_SO & Out_Ready_SI.
  - Simultaneous push and pop when full is allowed: occupancy stays 2.
  - Push when full with no pop: the new sample is dropped, the buffer is unchanged, and Ovf_SO is set.
  - DEC_Out_DO holds its last value when empty.
- Handshake: once Out_Valid_SO=1, it and DEC_Out_DO stay stable until accepted.
- Reset mid-operation: all state returns to reset values on the next edge. Samples in flight are discarded.

Optional Feature:
- SYM_DEC_DROPCNT_EN defined:
  - Adds output port Drop_Cnt_DO [15:0]. It increments on every dropped sample and saturates at 16'hFFFF.
  - It is cleared by reset or by a CTRL write.
  - Readable as a level only; it is not on the register bus.
- SYM_DEC_DROPCNT_EN undefined: the port and the counter are absent. Ovf_SO behaviour is identical in both builds.

Decomposition:
- Package sym_dec_pkg:
  - Register address constants: ADDR_RATIO=0, ADDR_PHASE=1, ADDR_SHIFT=2, ADDR_CTRL=3.
  - CTRL bit index EN_BIT=0.
  - Reset SHIFT default.
  - Saturation limit function/constants.
- Sub-module sym_dec_fifo:
  - 2-entry, OUT_WIDTH-wide.
  - Ports: push, pop, din, dout, empty, full.
  - Same clock and reset as the parent.

Test Plan:
- Reset defaults:
  - Stimulus: hold Rst_RI 3 cycles, then release.
  - Response: Out_Valid_SO=0, DEC_Out_DO=0, Ovf_SO=0; no output while EN=0 with ramp input.
- Basic decimation:
  - Stimulus: RATIO=4, PHASE=1, SHIFT=0, OUT_WIDTH=24 build; EN=1; input ramp 0,1,2,…; Out_Ready_SI=1.
  - Response: outputs 1,5,9,13…, one valid every 4 cycles; first valid 2 cycles after the selecting edge.
- Rounding and saturation (SHIFT=8, OUT_WIDTH=16):
  - Input 0x000180 -> 0x0002 (384/256=1.5 rounds to 2).
  - Input 0x7FFFFF -> 0x7FFF.
  - Input 0x800000 -> 0x8000.
  - Input 0xFFFF7F -> 0xFFFF (-129/256 rounds to -1).
- Phase clamp and counter restart:
  - Stimulus: RATIO=3, PHASE=7.
  - Response: effective phase 2.
  - Stimulus: mid-stream write of PHASE.
  - Response: cnt=0 the next cycle; the next selected sample is the 3rd after the write.
- Backpressure and overflow:
  - Stimulus: RATIO=1, Out_Ready_SI=0 for 5 selected samples.
  - Response: the first 2 samples are kept; samples 3–5 are dropped; Ovf_SO=1; Drop_Cnt_DO=3 when SYM_DEC_DROPCNT_EN is defined.
  - Stimulus: raise Out_Ready_SI.
  - Response: the 2 kept samples drain in order; a CTRL write clears Ovf_SO.
- Reset mid-stream:
  - Stimulus: assert Rst_RI with the buffer full.
  - Response: on the next edge, Out_Valid_SO=0, registers at defaults, and no stale sample appears afterwards.

Source files
------------

// File: rtl/sym_dec_pkg.sv
// sym_dec_pkg: shared constants and helpers for the symbol decimator.
// Register map, CTRL bit positions, reset SHIFT default and output
// saturation limits.
package sym_dec_pkg;

    // Config register addresses on the WrEn/Addr/data bus
    localparam int ADDR_RATIO = 0;
    localparam int ADDR_PHASE = 1;
    localparam int ADDR_SHIFT = 2;
    localparam int ADDR_CTRL  = 3;

    // CTRL register bit positions
    localparam int EN_BIT = 0;

    // Default SHIFT keeps the top OUT_WIDTH bits of an IN_WIDTH sample
    function automatic int shift_rst(input int in_w, input int out_w);
        return in_w - out_w;
    endfunction

    // Largest representable signed value of width out_w
    function automatic longint sat_hi(input int out_w);
        return (64'sd1 <<< (out_w - 1)) - 64'sd1;
    endfunction

    // Smallest representable signed value of width out_w
    function automatic longint sat_lo(input int out_w);
        return -(64'sd1 <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/sym_dec_fifo.sv
// sym_dec_fifo: 2-entry output buffer of the decimator.
// The head entry is a register that drives dout directly and keeps its
// value after the last entry is popped. A push into a full buffer is
// accepted only when a pop happens in the same cycle; otherwise it is
// ignored and the parent accounts for the drop.
module sym_dec_fifo #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    logic [1:0]       count_r;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;

    logic [1:0]       count_n_s;
    logic [WIDTH-1:0] head_n_s;
    logic [WIDTH-1:0] tail_n_s;
    logic             do_pop_s;
    logic             do_push_s;

    // Next buffer contents from the accepted push/pop combination
    always_comb begin
        count_n_s = count_r;
        head_n_s  = head_r;
        tail_n_s  = tail_r;
        do_pop_s  = pop & (count_r != 2'd0);
        do_push_s = push & ((count_r != 2'd2) | do_pop_s);
        case ({do_push_s, do_pop_s})
            2'b10: begin
                if (count_r == 2'd0) begin
                    head_n_s = din;
                end else begin
                    tail_n_s = din;
                end
                count_n_s = count_r + 2'd1;
            end
            2'b01: begin
                // Popping the last entry leaves the head value in place
                if (count_r == 2'd2) begin
                    head_n_s = tail_r;
                end else begin
                    head_n_s = head_r;
                end
                count_n_s = count_r - 2'd1;
            end
            2'b11: begin
                if (count_r == 2'd2) begin
                    head_n_s = tail_r;
                    tail_n_s = din;
                end else begin
                    head_n_s = din;
                end
            end
            default: begin
                count_n_s = count_r;
            end
        endcase
    end

    // Buffer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 2'd0;
            head_r  <= {WIDTH{1'b0}};
            tail_r  <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_n_s;
            head_r  <= head_n_s;
            tail_r  <= tail_n_s;
        end
    end

    assign dout  = head_r;
    assign empty = (count_r == 2'd0);
    assign full  = (count_r == 2'd2);

endmodule

// File: rtl/sym_dec.sv
// sym_dec: keeps one sample out of every M at phase P from the NYQ output
// stream, scales it by a rounded arithmetic right shift, saturates it to
// OUT_WIDTH and hands it out through a 2-entry valid/ready buffer.
// Pipeline: select/capture (stage 1) -> scale+saturate (stage 2) -> buffer.
// Optional build macro SYM_DEC_DROPCNT_EN adds the Drop_Cnt_DO counter of
// samples lost to a full buffer.
module sym_dec
    import sym_dec_pkg::*;
#(
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 32,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
    input  logic [IN_WIDTH-1:0]   DEC_In_DI,
    output logic                  Out_Valid_SO,
    input  logic                  Out_Ready_SI,
    output logic [OUT_WIDTH-1:0]  DEC_Out_DO,
    output logic                  Ovf_SO
`ifdef SYM_DEC_DROPCNT_EN
    ,
    output logic [15:0]           Drop_Cnt_DO
`endif
);

    localparam logic [ADDR_WIDTH-1:0] A_RATIO = ADDR_WIDTH'(ADDR_RATIO);
    localparam logic [ADDR_WIDTH-1:0] A_PHASE = ADDR_WIDTH'(ADDR_PHASE);
    localparam logic [ADDR_WIDTH-1:0] A_SHIFT = ADDR_WIDTH'(ADDR_SHIFT);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL  = ADDR_WIDTH'(ADDR_CTRL);

    localparam logic [CNT_WIDTH:0] M_ONE = (CNT_WIDTH+1)'(1);
    localparam logic [CNT_WIDTH:0] M_MAX = M_ONE << CNT_WIDTH;

    localparam logic [4:0] SHIFT_RST = 5'(shift_rst(IN_WIDTH, OUT_WIDTH));
    localparam logic [4:0] SHIFT_MAX = 5'(IN_WIDTH - 1);

    localparam logic signed [IN_WIDTH:0] EXT_ONE = (IN_WIDTH+1)'(1);
    localparam logic signed [IN_WIDTH:0] SAT_HI  = (IN_WIDTH+1)'(sat_hi(OUT_WIDTH));
    localparam logic signed [IN_WIDTH:0] SAT_LO  = (IN_WIDTH+1)'(sat_lo(OUT_WIDTH));

    // Configuration registers (ratio and shift are stored already clamped)
    logic [CNT_WIDTH:0]   ratio_r;
    logic [CNT_WIDTH-1:0] phase_r;
    logic [4:0]           shift_r;
    logic                 en_r;

    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 s1_valid_r;
    logic [IN_WIDTH-1:0]  s1_data_r;
    logic                 s2_valid_r;
    logic [OUT_WIDTH-1:0] s2_data_r;
    logic                 ovf_r;

    logic                 wr_ratio_s;
    logic                 wr_phase_s;
    logic                 wr_shift_s;
    logic                 wr_ctrl_s;
    logic [CNT_WIDTH:0]   ratio_in_s;
    logic [CNT_WIDTH:0]   ratio_new_s;
    logic [4:0]           shift_in_s;
    logic [4:0]           shift_new_s;
    logic [CNT_WIDTH-1:0] last_cnt_s;
    logic [CNT_WIDTH-1:0] eff_phase_s;
    logic                 sel_s;

    logic signed [IN_WIDTH:0] ext_s;
    logic signed [IN_WIDTH:0] rnd_s;
    logic signed [IN_WIDTH:0] sum_s;
    logic signed [IN_WIDTH:0] shd_s;
    logic [OUT_WIDTH-1:0]     sat_s;

    logic                 fifo_empty_s;
    logic                 fifo_full_s;
    logic                 pop_s;
    logic                 drop_s;
    logic                 unused_s;

    assign wr_ratio_s = WrEn_SI & (Addr_DI == A_RATIO);
    assign wr_phase_s = WrEn_SI & (Addr_DI == A_PHASE);
    assign wr_shift_s = WrEn_SI & (Addr_DI == A_SHIFT);
    assign wr_ctrl_s  = WrEn_SI & (Addr_DI == A_CTRL);
    assign unused_s   = ^PAR_In_DI;

    // Clamp incoming RATIO and SHIFT values to their legal ranges
    always_comb begin
        ratio_in_s = PAR_In_DI[CNT_WIDTH:0];
        shift_in_s = PAR_In_DI[4:0];
        if (ratio_in_s == {(CNT_WIDTH+1){1'b0}}) begin
            ratio_new_s = M_ONE;
        end else if (ratio_in_s > M_MAX) begin
            ratio_new_s = M_MAX;
        end else begin
            ratio_new_s = ratio_in_s;
        end
        if (shift_in_s > SHIFT_MAX) begin
            shift_new_s = SHIFT_MAX;
        end else begin
            shift_new_s = shift_in_s;
        end
    end

    // Effective phase (clamped to M-1) and sample selection
    always_comb begin
        last_cnt_s = CNT_WIDTH'(ratio_r - M_ONE);
        if ({1'b0, phase_r} >= ratio_r) begin
            eff_phase_s = last_cnt_s;
        end else begin
            eff_phase_s = phase_r;
        end
        sel_s = en_r & (cnt_r == eff_phase_s);
    end

    // Configuration register file
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            ratio_r <= M_ONE;
            phase_r <= {CNT_WIDTH{1'b0}};
            shift_r <= SHIFT_RST;
            en_r    <= 1'b0;
        end else begin
            if (wr_ratio_s) ratio_r <= ratio_new_s;
            if (wr_phase_s) phase_r <= PAR_In_DI[CNT_WIDTH-1:0];
            if (wr_shift_s) shift_r <= shift_new_s;
            if (wr_ctrl_s)  en_r    <= PAR_In_DI[EN_BIT];
        end
    end

    // Decimation counter: restarts on RATIO/PHASE/CTRL writes, idle at 0 when disabled
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (wr_ratio_s | wr_phase_s | wr_ctrl_s) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (!en_r) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (cnt_r == last_cnt_s) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Round half up, arithmetic shift, then saturate to OUT_WIDTH
    always_comb begin
        ext_s = {s1_data_r[IN_WIDTH-1], s1_data_r};
        if (shift_r != 5'd0) begin
            rnd_s = EXT_ONE << (shift_r - 5'd1);
        end else begin
            rnd_s = {(IN_WIDTH+1){1'b0}};
        end
        sum_s = ext_s + rnd_s;
        shd_s = sum_s >>> shift_r;
        if (shd_s > SAT_HI) begin
            sat_s = SAT_HI[OUT_WIDTH-1:0];
        end else if (shd_s < SAT_LO) begin
            sat_s = SAT_LO[OUT_WIDTH-1:0];
        end else begin
            sat_s = shd_s[OUT_WIDTH-1:0];
        end
    end

    // Two-stage datapath: capture selected sample, then register scaled result
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {IN_WIDTH{1'b0}};
            s2_valid_r <= 1'b0;
            s2_data_r  <= {OUT_WIDTH{1'b0}};
        end else begin
            s1_valid_r <= sel_s;
            if (sel_s) s1_data_r <= DEC_In_DI;
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) s2_data_r <= sat_s;
        end
    end

    assign pop_s  = ~fifo_empty_s & Out_Ready_SI;
    assign drop_s = s2_valid_r & fifo_full_s & ~pop_s;

    sym_dec_fifo #(
        .WIDTH (OUT_WIDTH)
    ) u_fifo (
        .clk   (Clk_CI),
        .rst   (Rst_RI),
        .push  (s2_valid_r),
        .pop   (pop_s),
        .din   (s2_data_r),
        .dout  (DEC_Out_DO),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    assign Out_Valid_SO = ~fifo_empty_s;

    // Sticky overflow flag: a drop in the same cycle as a CTRL write wins
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (wr_ctrl_s) begin
            ovf_r <= 1'b0;
        end
    end

    assign Ovf_SO = ovf_r;

`ifdef SYM_DEC_DROPCNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating count of dropped samples; a CTRL write restarts it
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            drop_cnt_r <= 16'd0;
        end else if (wr_ctrl_s) begin
            drop_cnt_r <= drop_s ? 16'd1 : 16'd0;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end

    assign Drop_Cnt_DO = drop_cnt_r;
`endif

endmodule

// File: tb/tb_sym_dec.sv
// tb_sym_dec: directed scenarios plus randomized traffic, all checked every
// cycle against a behavioural model of the decimator kept in this bench.
module tb_sym_dec;
    import sym_dec_pkg::*;

    logic        Clk_CI = 1'b0;
    logic        Rst_RI;
    logic        WrEn_SI;
    logic [4:0]  Addr_DI;
    logic [31:0] PAR_In_DI;
    logic [23:0] DEC_In_DI;
    logic        Out_Valid_SO;
    logic        Out_Ready_SI;
    logic [15:0] DEC_Out_DO;
    logic        Ovf_SO;
`ifdef SYM_DEC_DROPCNT_EN
    logic [15:0] Drop_Cnt_DO;
`endif

    always #5 Clk_CI = ~Clk_CI;

    sym_dec dut (
        .Clk_CI       (Clk_CI),
        .Rst_RI       (Rst_RI),
        .WrEn_SI      (WrEn_SI),
        .Addr_DI      (Addr_DI),
        .PAR_In_DI    (PAR_In_DI),
        .DEC_In_DI    (DEC_In_DI),
        .Out_Valid_SO (Out_Valid_SO),
        .Out_Ready_SI (Out_Ready_SI),
        .DEC_Out_DO   (DEC_Out_DO),
        .Ovf_SO       (Ovf_SO)
`ifdef SYM_DEC_DROPCNT_EN
        ,
        .Drop_Cnt_DO  (Drop_Cnt_DO)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_init = 1'b0;
    int          m_m, m_ph, m_sh, m_cnt;
    bit          m_en;
    bit          m_s1v, m_s2v;
    logic [23:0] m_s1;
    int          m_s2;
    int          fq[$];
    int          m_last;
    bit          m_ovf;
    int          m_drops;
    int          got_q[$];

    // value of x * 2^-sh rounded half up, clipped to 16-bit signed
    function automatic int scale(input logic [23:0] x, input int sh);
        longint v;
        v = longint'($signed(x));
        if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
        v = v >>> sh;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return int'(v);
    endfunction

    task automatic model_edge();
        bit pop, drop, sel;
        int effph, v;
        if (Rst_RI) begin
            m_init = 1'b1;
            m_m = 1; m_ph = 0; m_sh = 8; m_en = 1'b0; m_cnt = 0;
            m_s1v = 1'b0; m_s2v = 1'b0; m_s1 = 24'd0; m_s2 = 0;
            fq.delete();
            m_last = 0; m_ovf = 1'b0; m_drops = 0;
        end else if (m_init) begin
            pop  = (fq.size() > 0) && Out_Ready_SI;
            drop = m_s2v && (fq.size() == 2) && !pop;
            if (pop) void'(fq.pop_front());
            if (m_s2v && !drop) fq.push_back(m_s2);
            if (fq.size() > 0) m_last = fq[0];
            if (WrEn_SI && Addr_DI == 5'd3) begin
                m_ovf = 1'b0;
                m_drops = 0;
            end
            if (drop) begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
            effph = (m_ph >= m_m) ? m_m - 1 : m_ph;
            sel = m_en && (m_cnt == effph);
            m_s2v = m_s1v;
            m_s2  = scale(m_s1, m_sh);
            m_s1v = sel;
            if (sel) m_s1 = DEC_In_DI;
            if (WrEn_SI && (Addr_DI == 5'd0 || Addr_DI == 5'd1 || Addr_DI == 5'd3)) m_cnt = 0;
            else if (!m_en) m_cnt = 0;
            else m_cnt = (m_cnt + 1) % m_m;
            if (WrEn_SI) begin
                case (Addr_DI)
                    5'd0: begin
                        v = int'(PAR_In_DI & 32'h1F);
                        m_m = (v == 0) ? 1 : ((v > 16) ? 16 : v);
                    end
                    5'd1: m_ph = int'(PAR_In_DI & 32'hF);
                    5'd2: begin
                        v = int'(PAR_In_DI & 32'h1F);
                        m_sh = (v > 23) ? 23 : v;
                    end
                    5'd3: m_en = PAR_In_DI[0];
                    default: ;
                endcase
            end
        end
    endtask

    always begin
        @(posedge Clk_CI);
        model_edge();
    end

    // per-cycle comparison and accepted-output log
    always begin
        @(negedge Clk_CI);
        if (m_init) begin
            chk("valid", Out_Valid_SO, fq.size() > 0);
            chk("data", $signed(DEC_Out_DO), m_last);
            chk("ovf", Ovf_SO, m_ovf);
`ifdef SYM_DEC_DROPCNT_EN
            chk("dropcnt", Drop_Cnt_DO, m_drops);
`endif
            if (Out_Valid_SO && Out_Ready_SI) got_q.push_back(int'($signed(DEC_Out_DO)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [23:0] din);
        DEC_In_DI = din;
        @(posedge Clk_CI);
        #2;
    endtask

    task automatic wr(input int addr, input int data, input logic [23:0] din);
        WrEn_SI   = 1'b1;
        Addr_DI   = 5'(addr);
        PAR_In_DI = 32'(data);
        step(din);
        WrEn_SI   = 1'b0;
    endtask

    task automatic expect_seq(input string name, input int n0, input int exp[$]);
        chk({name, "_count"}, got_q.size() >= n0 + exp.size(), 1);
        if (got_q.size() >= n0 + exp.size()) begin
            foreach (exp[k]) chk(name, got_q[n0 + k], exp[k]);
        end
    endtask

    initial begin
        int n0;
        int tmp;
        Rst_RI = 1'b1; WrEn_SI = 1'b0; Addr_DI = 5'd0; PAR_In_DI = 32'd0;
        DEC_In_DI = 24'd0; Out_Ready_SI = 1'b1;

        // reset defaults, no output while disabled
        repeat (3) step(24'd0);
        Rst_RI = 1'b0;
        chk("rst_valid", Out_Valid_SO, 0);
        chk("rst_data", DEC_Out_DO, 0);
        chk("rst_ovf", Ovf_SO, 0);
        n0 = got_q.size();
        for (int j = 0; j < 12; j++) step(24'(j));
        chk("idle_no_out", got_q.size(), n0);

        // basic decimation M=4, P=1, no scaling
        wr(ADDR_SHIFT, 0, 24'd0);
        wr(ADDR_RATIO, 4, 24'd0);
        wr(ADDR_PHASE, 1, 24'd0);
        n0 = got_q.size();
        wr(ADDR_CTRL, 1, 24'd0);
        for (int j = 1; j <= 20; j++) begin
            step(24'(j));
            if (j == 3) chk("lat_early", Out_Valid_SO, 0);
            if (j == 4) begin
                chk("lat_valid", Out_Valid_SO, 1);
                chk("lat_data", $signed(DEC_Out_DO), 2);
            end
        end
        expect_seq("dec_seq", n0, '{2, 6, 10, 14});
        wr(ADDR_CTRL, 0, 24'd0);
        repeat (6) step(24'd0);

        // rounding and saturation with SHIFT=8
        wr(ADDR_RATIO, 1, 24'd0);
        wr(ADDR_PHASE, 0, 24'd0);
        wr(ADDR_SHIFT, 8, 24'd0);
        n0 = got_q.size();
        wr(ADDR_CTRL, 1, 24'd0);
        step(24'h000180);
        step(24'h7FFFFF);
        step(24'h800000);
        step(24'hFFFF7F);
        wr(ADDR_CTRL, 0, 24'd0);
        repeat (6) step(24'd0);
        expect_seq("round_sat", n0, '{2, 32767, -32768, -1});

        // phase clamp (M=3, P=7 -> 2) and counter restart on PHASE write
        wr(ADDR_SHIFT, 0, 24'd0);
        wr(ADDR_RATIO, 3, 24'd0);
        wr(ADDR_PHASE, 7, 24'd0);
        n0 = got_q.size();
        wr(ADDR_CTRL, 1, 24'd0);
        for (int j = 1; j <= 10; j++) step(24'(j));
        wr(ADDR_PHASE, 7, 24'd11);
        for (int j = 12; j <= 20; j++) step(24'(j));
        wr(ADDR_CTRL, 0, 24'd0);
        repeat (6) step(24'd0);
        expect_seq("phase", n0, '{3, 6, 9, 14, 17, 20});

        // backpressure: 5 selected samples, ready low
        wr(ADDR_RATIO, 1, 24'd0);
        wr(ADDR_PHASE, 15, 24'd0);
        Out_Ready_SI = 1'b0;
        n0 = got_q.size();
        wr(ADDR_CTRL, 1, 24'd0);
        for (int j = 1; j <= 4; j++) step(24'(100 + j));
        wr(ADDR_RATIO, 16, 24'd105);
        step(24'd0);
        step(24'd0);
        chk("bp_valid", Out_Valid_SO, 1);
        chk("bp_head", $signed(DEC_Out_DO), 101);
        chk("bp_ovf", Ovf_SO, 1);
`ifdef SYM_DEC_DROPCNT_EN
        chk("bp_drops", Drop_Cnt_DO, 3);
`endif
        chk("bp_none_taken", got_q.size(), n0);
        Out_Ready_SI = 1'b1;
        repeat (4) step(24'd0);
        chk("bp_drained", Out_Valid_SO, 0);
        chk("bp_ovf_sticky", Ovf_SO, 1);
        chk("bp_drain_count", got_q.size(), n0 + 2);
        expect_seq("bp_drain", n0, '{101, 102});
        wr(ADDR_CTRL, 0, 24'd0);
        chk("bp_ovf_clear", Ovf_SO, 0);

        // reset with the buffer full
        wr(ADDR_RATIO, 1, 24'd0);
        wr(ADDR_PHASE, 0, 24'd0);
        Out_Ready_SI = 1'b0;
        wr(ADDR_CTRL, 1, 24'd0);
        repeat (5) step(24'd50);
        Rst_RI = 1'b1;
        step(24'd0);
        Rst_RI = 1'b0;
        chk("mrst_valid", Out_Valid_SO, 0);
        chk("mrst_data", DEC_Out_DO, 0);
        chk("mrst_ovf", Ovf_SO, 0);
        Out_Ready_SI = 1'b1;
        n0 = got_q.size();
        repeat (8) step(24'd50);
        chk("mrst_no_stale", got_q.size(), n0);
        wr(ADDR_CTRL, 1, 24'd0);
        step(24'h000180);
        wr(ADDR_CTRL, 0, 24'd0);
        repeat (6) step(24'd0);
        expect_seq("mrst_defaults", n0, '{2, 0});

        // randomized traffic, configuration and occasional reset
        wr(ADDR_CTRL, 1, 24'd0);
        for (int c = 0; c < 3000; c++) begin
            Out_Ready_SI = ($urandom_range(0, 3) != 0);
            Rst_RI = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 15) == 0) begin
                WrEn_SI = 1'b1;
                Addr_DI = 5'($urandom_range(0, 7));
                tmp = int'($urandom);
                if (Addr_DI == 5'd3) tmp[0] = ($urandom_range(0, 7) != 0);
                PAR_In_DI = 32'(tmp);
            end else begin
                WrEn_SI = 1'b0;
            end
            step(24'($urandom));
        end
        Rst_RI = 1'b0;
        WrEn_SI = 1'b0;
        Out_Ready_SI = 1'b1;
        repeat (8) step(24'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
